// File: rtl/bip_pkg.sv
// bip_pkg: opcodes, sequencer/serializer state encodings and the fixed program ROM.
// The BIP_UART_TX_PC_EN build uses the SEQ_SEND_PC_* states; the default build never enters them.
package bip_pkg;

   localparam logic [4:0] OP_HLT  = 5'd0;
   localparam logic [4:0] OP_STO  = 5'd1;
   localparam logic [4:0] OP_LD   = 5'd2;
   localparam logic [4:0] OP_LDI  = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_ADDI = 5'd5;
   localparam logic [4:0] OP_SUB  = 5'd6;
   localparam logic [4:0] OP_SUBI = 5'd7;

   typedef enum logic [2:0] {
      SEQ_WAIT_HALT,
      SEQ_SEND_LO,
      SEQ_SEND_HI,
      SEQ_SEND_PC_LO,
      SEQ_SEND_PC_HI,
      SEQ_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   // Fixed program; every word past the listing is HLT.
   function automatic logic [15:0] rom_word(input logic [31:0] addr);
      logic [15:0] w;
      case (addr)
         32'd0:   w = {OP_LDI,  11'h005};
         32'd1:   w = {OP_STO,  11'h000};
         32'd2:   w = {OP_ADDI, 11'h123};
         32'd3:   w = {OP_ADD,  11'h000};
         32'd4:   w = {OP_SUBI, 11'h001};
         32'd5:   w = {OP_STO,  11'h001};
         32'd6:   w = {OP_SUB,  11'h000};
         default: w = {OP_HLT,  11'h000};
      endcase
      return w;
   endfunction

endpackage

// File: rtl/bip_uart_tx.sv
// bip_uart_tx: 8N1 serializer; each bit, stop included, lasts SBTICK baud ticks.
module bip_uart_tx
   import bip_pkg::*;
#(
   parameter int DBIT   = 8,
   parameter int SBTICK = 16
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_tick,
   input  logic            i_start,
   input  logic [DBIT-1:0] i_data,
   output logic            o_tx,
   output logic            o_tx_done
);

   localparam int SW = $clog2(SBTICK);
   localparam int NW = $clog2(DBIT);

   tx_state_t       state;
   logic [SW-1:0]   s_cnt;
   logic [NW-1:0]   n_cnt;
   logic [DBIT-1:0] shreg;
   logic            tx_reg;
   logic            bit_end;

   assign bit_end   = i_tick && (s_cnt == SW'(SBTICK-1));
   assign o_tx_done = (state == TX_STOP) && bit_end;
   // The line drops in the same cycle as the request, so a frame launched from
   // o_tx_done abuts the previous stop bit with no idle gap.
   assign o_tx      = tx_reg & ~((state == TX_IDLE) & i_start);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= TX_IDLE;
         s_cnt  <= '0;
         n_cnt  <= '0;
         shreg  <= '0;
         tx_reg <= 1'b1;
      end else begin
         case (state)
            TX_IDLE: if (i_start) begin
               state  <= TX_START;
               s_cnt  <= '0;
               shreg  <= i_data;
               tx_reg <= 1'b0;
            end
            TX_START: if (i_tick) begin
               if (bit_end) begin
                  state  <= TX_DATA;
                  s_cnt  <= '0;
                  n_cnt  <= '0;
                  tx_reg <= shreg[0];
               end else s_cnt <= s_cnt + 1'b1;
            end
            TX_DATA: if (i_tick) begin
               if (bit_end) begin
                  s_cnt <= '0;
                  if (n_cnt == NW'(DBIT-1)) begin
                     state  <= TX_STOP;
                     tx_reg <= 1'b1;
                  end else begin
                     n_cnt  <= n_cnt + 1'b1;
                     shreg  <= shreg >> 1;
                     tx_reg <= shreg[1];
                  end
               end else s_cnt <= s_cnt + 1'b1;
            end
            TX_STOP: if (i_tick) begin
               if (bit_end) state <= TX_IDLE;
               else s_cnt <= s_cnt + 1'b1;
            end
            default: state <= TX_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bip_uart_top.sv
// bip_uart_top: BIP accumulator CPU runs the ROM to HLT, then sends ACC over UART (low byte first).
// Define BIP_UART_TX_PC_EN to also send the halt PC as two more bytes.
module bip_uart_top
   import bip_pkg::*;
#(
   parameter int NBITS_O = 11,
   parameter int NBITS_E = 5,
   parameter int NBITS_D = 16,
   parameter int OPCODE  = 5,
   parameter int CELDAS  = 10,
   parameter int DBIT    = 8,
   parameter int SBTICK  = 16,
   parameter int SIZ     = 8,
   parameter int DIV     = 6
) (
   input  logic i_clk,
   input  logic i_rst,
   output logic o_tx
);

   localparam int AW = $clog2(CELDAS);

   logic [SIZ-1:0] tick_cnt;
   logic           tick;

   assign tick = (tick_cnt == SIZ'(DIV-1));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)     tick_cnt <= '0;
      else if (tick) tick_cnt <= '0;
      else           tick_cnt <= tick_cnt + 1'b1;
   end

   logic [NBITS_E-1:0] pc;
   logic [NBITS_D-1:0] acc;
   logic               halted;
   logic [NBITS_D-1:0] instr;
   logic [OPCODE-1:0]  opc;
   logic [NBITS_O-1:0] operand;
   logic [NBITS_D-1:0] imm_sx;
   logic [NBITS_D-1:0] mem_rd;
   logic [AW-1:0]      maddr;
   logic               in_range;
   logic [NBITS_D-1:0] mem [CELDAS];

   assign instr    = rom_word(32'(pc));
   assign opc      = instr[NBITS_D-1 -: OPCODE];
   assign operand  = instr[NBITS_O-1:0];
   assign imm_sx   = {{(NBITS_D-NBITS_O){operand[NBITS_O-1]}}, operand};
   assign maddr    = operand[AW-1:0];
   assign in_range = operand < NBITS_O'(CELDAS);
   assign mem_rd   = in_range ? mem[maddr] : '0;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         pc     <= '0;
         acc    <= '0;
         halted <= 1'b0;
      end else if (!halted) begin
         if (opc == OP_HLT) halted <= 1'b1;
         else begin
            pc <= pc + 1'b1;
            case (opc)
               OP_LD:   acc <= mem_rd;
               OP_LDI:  acc <= imm_sx;
               OP_ADD:  acc <= acc + mem_rd;
               OP_ADDI: acc <= acc + imm_sx;
               OP_SUB:  acc <= acc - mem_rd;
               OP_SUBI: acc <= acc - imm_sx;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int i = 0; i < CELDAS; i++) mem[i] <= '0;
      end else if (!halted && opc == OP_STO && in_range) begin
         mem[maddr] <= acc;
      end
   end

   seq_state_t                state;
   logic                      tx_start;
   logic [DBIT-1:0]           tx_data;
   logic [NBITS_D-DBIT-1:0]   acc_hi;
   logic                      tx_done;
`ifdef BIP_UART_TX_PC_EN
   logic [NBITS_D-1:0]        pc_word;
   assign pc_word = NBITS_D'(pc);
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state    <= SEQ_WAIT_HALT;
         tx_start <= 1'b0;
         tx_data  <= '0;
         acc_hi   <= '0;
      end else begin
         tx_start <= 1'b0;
         case (state)
            SEQ_WAIT_HALT: if (halted) begin
               acc_hi   <= acc[NBITS_D-1:DBIT];
               tx_data  <= acc[DBIT-1:0];
               tx_start <= 1'b1;
               state    <= SEQ_SEND_LO;
            end
            SEQ_SEND_LO: if (tx_done) begin
               tx_data  <= acc_hi;
               tx_start <= 1'b1;
               state    <= SEQ_SEND_HI;
            end
            SEQ_SEND_HI: if (tx_done) begin
`ifdef BIP_UART_TX_PC_EN
               tx_data  <= pc_word[DBIT-1:0];
               tx_start <= 1'b1;
               state    <= SEQ_SEND_PC_LO;
`else
               state    <= SEQ_DONE;
`endif
            end
`ifdef BIP_UART_TX_PC_EN
            SEQ_SEND_PC_LO: if (tx_done) begin
               tx_data  <= pc_word[NBITS_D-1:DBIT];
               tx_start <= 1'b1;
               state    <= SEQ_SEND_PC_HI;
            end
            SEQ_SEND_PC_HI: if (tx_done) state <= SEQ_DONE;
`endif
            default: ;
         endcase
      end
   end

   bip_uart_tx #(
      .DBIT   (DBIT),
      .SBTICK (SBTICK)
   ) u_tx (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_tick    (tick),
      .i_start   (tx_start),
      .i_data    (tx_data),
      .o_tx      (o_tx),
      .o_tx_done (tx_done)
   );

endmodule

// File: tb/tb_bip_uart_top.sv
// tb_bip_uart_top: runs the BIP program, decodes the serial line with a mid-bit sampler
// and compares against a program-level model; includes a reset issued mid-frame.
`timescale 1ns/1ps
module tb_bip_uart_top;

   localparam int BITCLK = 96;

   logic i_clk = 1'b0;
   logic i_rst = 1'b0;
   logic o_tx;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rel_cyc = 0;
   int base_idx = 0;

   int          ev_cyc[$];
   logic        ev_val[$];
   logic        last_tx = 1'b1;

   int          m_acc, m_pc, m_steps;
   int          m_mem[10];
   logic [7:0]  exp_bytes[$];

   int unsigned prog_op [8] = '{3, 1, 5, 4, 7, 1, 6, 0};
   int unsigned prog_imm[8] = '{5, 0, 'h123, 0, 1, 1, 0, 0};

   bip_uart_top dut (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .o_tx  (o_tx)
   );

   always #50 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   always @(negedge i_clk) begin
      if (o_tx !== last_tx) begin
         ev_cyc.push_back(cyc);
         ev_val.push_back(o_tx);
         last_tx = o_tx;
      end
   end

   initial begin
      #(100 * 60000);
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   task automatic model_run();
      int pc = 0, acc = 0, steps = 0, op, imm, simm, rd;
      foreach (m_mem[i]) m_mem[i] = 0;
      for (int k = 0; k < 64; k++) begin
         op  = (pc < 8) ? int'(prog_op[pc])  : 0;
         imm = (pc < 8) ? int'(prog_imm[pc]) : 0;
         if (op == 0) break;
         simm = (imm >= 1024) ? imm - 2048 : imm;
         rd   = (imm < 10) ? m_mem[imm] : 0;
         case (op)
            1: if (imm < 10) m_mem[imm] = acc;
            2: acc = rd;
            3: acc = simm;
            4: acc = acc + rd;
            5: acc = acc + simm;
            6: acc = acc - rd;
            7: acc = acc - simm;
            default: ;
         endcase
         acc   = acc & 32'hFFFF;
         pc    = (pc + 1) % 32;
         steps = steps + 1;
      end
      m_acc = acc; m_pc = pc; m_steps = steps;
      exp_bytes.push_back(8'(acc & 255));
      exp_bytes.push_back(8'(acc >> 8));
`ifdef BIP_UART_TX_PC_EN
      exp_bytes.push_back(8'(pc & 255));
      exp_bytes.push_back(8'(pc >> 8));
`endif
   endtask

   task automatic release_reset();
      @(negedge i_clk);
      i_rst    = 1'b0;
      rel_cyc  = cyc;
      base_idx = ev_cyc.size();
   endtask

   task automatic test_reset();
      int hold = $urandom_range(2, 6);
      #5 i_rst = 1'b1;
      repeat (hold) begin
         @(negedge i_clk);
         checks++;
         if (o_tx !== 1'b1 || dut.pc !== '0 || dut.acc !== '0 || dut.halted !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: o_tx=%b pc=%0d acc=%h halted=%b, required 1/0/0000/0",
                     o_tx, dut.pc, dut.acc, dut.halted);
         end
      end
      release_reset();
   endtask

   task automatic test_cpu();
      int budget = 0;
      while (dut.halted !== 1'b1 && budget < 200) begin
         checks++;
         if (o_tx !== 1'b1) begin
            failures++;
            $display("FAIL pre_halt_idle: o_tx=%b at cycle %0d, required 1", o_tx, cyc - rel_cyc);
         end
         @(negedge i_clk);
         budget++;
      end
      checks++;
      if (dut.halted !== 1'b1) begin
         failures++;
         $display("FAIL halt_timeout: halted=%b after %0d cycles, required 1", dut.halted, budget);
      end
      checks++;
      if (cyc - rel_cyc != m_steps + 1) begin
         failures++;
         $display("FAIL halt_cycle: halted seen at cycle %0d, required %0d", cyc - rel_cyc, m_steps + 1);
      end
      checks++;
      if (dut.pc !== 5'(m_pc)) begin
         failures++;
         $display("FAIL halt_pc: got %0d, required %0d", dut.pc, m_pc);
      end
      checks++;
      if (dut.acc !== 16'(m_acc)) begin
         failures++;
         $display("FAIL halt_acc: got %h, required %h", dut.acc, 16'(m_acc));
      end
      checks++;
      if (dut.mem[0] !== 16'(m_mem[0]) || dut.mem[1] !== 16'(m_mem[1])) begin
         failures++;
         $display("FAIL ram: mem0=%h mem1=%h, required %h %h",
                  dut.mem[0], dut.mem[1], 16'(m_mem[0]), 16'(m_mem[1]));
      end
   endtask

   task automatic test_loopback();
      logic [9:0]  bits;
      logic [7:0]  rx[$];
      logic [15:0] word;
      int          t0, budget;
      for (int k = 0; k < exp_bytes.size(); k++) begin
         budget = 0;
         while (o_tx !== 1'b0 && budget < 3000) begin
            @(negedge i_clk);
            budget++;
         end
         checks++;
         if (o_tx !== 1'b0) begin
            failures++;
            $display("FAIL rx_start byte%0d: line=%b after %0d cycles, required start bit 0", k, o_tx, budget);
            break;
         end
         t0 = cyc;
         for (int i = 0; i < 10; i++) begin
            while (cyc < t0 + BITCLK/2 + BITCLK*i) @(negedge i_clk);
            bits[i] = o_tx;
         end
         checks++;
         if (bits[0] !== 1'b0 || bits[9] !== 1'b1) begin
            failures++;
            $display("FAIL rx_framing byte%0d: start=%b stop=%b, required 0 and 1", k, bits[0], bits[9]);
         end
         rx.push_back(bits[8:1]);
         checks++;
         if (bits[8:1] !== exp_bytes[k]) begin
            failures++;
            $display("FAIL rx_byte%0d: got %h, required %h", k, bits[8:1], exp_bytes[k]);
         end
      end
      if (rx.size() >= 2) begin
         word = {rx[1], rx[0]};
         checks++;
         if (word !== 16'(m_acc)) begin
            failures++;
            $display("FAIL rx_word: got %h, required %h", word, 16'(m_acc));
         end
      end
      budget = 0;
      while (budget < 1100 && o_tx === 1'b1) begin
         @(negedge i_clk);
         budget++;
      end
      checks++;
      if (o_tx !== 1'b1) begin
         failures++;
         $display("FAIL rx_extra: line=%b %0d cycles after last byte, required idle 1", o_tx, budget);
      end
   endtask

   task automatic test_frame_timing();
      logic lvl[$];
      int   pos[$];
      logic prev = 1'b1;
      int   n, d, want;
      foreach (exp_bytes[k]) begin
         lvl.push_back(1'b0);
         for (int i = 0; i < 8; i++) lvl.push_back(exp_bytes[k][i]);
         lvl.push_back(1'b1);
      end
      foreach (lvl[p]) begin
         if (lvl[p] !== prev) pos.push_back(p);
         prev = lvl[p];
      end
      n = ev_cyc.size() - base_idx;
      checks++;
      if (n != pos.size()) begin
         failures++;
         $display("FAIL edge_count: got %0d line transitions, required %0d", n, pos.size());
      end
      if (n >= 2 && n == pos.size()) begin
         checks++;
         if (ev_cyc[base_idx] - rel_cyc < m_steps + 1) begin
            failures++;
            $display("FAIL early_start: first start at cycle %0d, required >= %0d",
                     ev_cyc[base_idx] - rel_cyc, m_steps + 1);
         end
         // First start bit may be shortened by the free-running tick phase.
         d = (ev_cyc[base_idx+1] - ev_cyc[base_idx]) + (pos[1] - 1) * BITCLK;
         checks++;
         if (d > BITCLK * pos[1] || d < BITCLK * pos[1] - 6) begin
            failures++;
            $display("FAIL first_bit_len: got %0d clocks, required %0d..%0d", d,
                     BITCLK * pos[1] - 6, BITCLK * pos[1]);
         end
         for (int j = 0; j < n; j++) begin
            checks++;
            if (ev_val[base_idx+j] !== lvl[pos[j]]) begin
               failures++;
               $display("FAIL edge_level%0d: got %b, required %b", j, ev_val[base_idx+j], lvl[pos[j]]);
            end
         end
         for (int j = 2; j < n; j++) begin
            d    = ev_cyc[base_idx+j] - ev_cyc[base_idx+1];
            want = BITCLK * (pos[j] - pos[1]);
            checks++;
            if (d != want) begin
               failures++;
               $display("FAIL edge_time%0d: got %0d clocks after first edge, required %0d", j, d, want);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      int budget = 0;
      @(negedge i_clk);
      #10 i_rst = 1'b1;
      repeat ($urandom_range(2, 5)) @(negedge i_clk);
      release_reset();
      while (o_tx !== 1'b0 && budget < 3000) begin
         @(negedge i_clk);
         budget++;
      end
      repeat ($urandom_range(5, 80)) @(negedge i_clk);
      checks++;
      if (o_tx !== 1'b0) begin
         failures++;
         $display("FAIL mid_frame_pre: line=%b inside start bit, required 0", o_tx);
      end
      #($urandom_range(5, 40)) i_rst = 1'b1;
      #1;
      checks++;
      if (o_tx !== 1'b1 || dut.pc !== '0 || dut.halted !== 1'b0) begin
         failures++;
         $display("FAIL mid_frame_reset: o_tx=%b pc=%0d halted=%b, required 1/0/0", o_tx, dut.pc, dut.halted);
      end
      repeat ($urandom_range(1, 4)) @(negedge i_clk);
      release_reset();
      test_cpu();
      test_loopback();
      test_frame_timing();
   endtask

   initial begin
      model_run();
      test_reset();
      test_cpu();
      test_loopback();
      test_frame_timing();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
